// File: rtl/ula_mdu_control.sv
// rtl/ula_mdu_control.sv - EX-stage ALU control decoder with multi-cycle MUL/DIV unit and HI/LO
//
// Purpose: decodes ula_operation/func into the 4-bit ALU operation code and runs
//   MULT/MULTU/DIV/DIVU (shift-add / restoring divide, one bit per cycle),
//   MTHI/MTLO/MFHI/MFLO, and a stall handshake towards pipeline control.
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   ula_operation, func, start op class, R-type funct, EX instruction valid
//   operand_a, operand_b      rs / rt values
//   operation                 ALU operation code (combinational)
//   mdu_sel, mdu_result       EX result source select and HI/LO read value
//   busy, stall, done         MDU in progress, pipeline hold, HI/LO-updated pulse
//   hi, lo                    HI/LO registers
module ula_mdu_control #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [2:0]            ula_operation,
  input  logic [5:0]            func,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [3:0]            operation,
  output logic                  mdu_sel,
  output logic [DATA_WIDTH-1:0] mdu_result,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [W-1:0]         r_rem;     // MUL: product high half / DIV: partial remainder
  logic [W-1:0]         r_quo;     // MUL: multiplier, shifted out as product low half / DIV: dividend -> quotient
  logic [W-1:0]         r_opnd;    // MUL: multiplicand magnitude / DIV: divisor magnitude
  logic [W-1:0]         r_hi;
  logic [W-1:0]         r_lo;
  logic                 r_neg_q;   // product or quotient must be negated
  logic                 r_neg_r;   // remainder must be negated (dividend was negative)
  logic                 r_is_div;
  logic                 r_done;

  logic         w_req;
  logic         w_muldiv;
  logic         w_mt;
  logic         w_mfhi;
  logic         w_mflo;
  logic         w_signed;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [W-1:0] w_a_mag;
  logic [W-1:0] w_b_mag;
  logic [W:0]   w_add;
  logic [W:0]   w_shift;
  logic         w_ge;
  logic [W-1:0] w_diff;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0] w_quo_fix;
  logic [W-1:0] w_rem_fix;

  assign w_req    = start & (ula_operation == 3'b010);
  assign w_muldiv = w_req & (func[5:2] == 4'b0110);
  assign w_mt     = w_req & ((func == 6'b010001) | (func == 6'b010011));
  assign w_mfhi   = w_req & (func == 6'b010000);
  assign w_mflo   = w_req & (func == 6'b010010);

  // MULT and DIV have funct bit 0 clear; the unsigned variants have it set
  assign w_signed = ~func[0];
  assign w_a_neg  = w_signed & operand_a[W-1];
  assign w_b_neg  = w_signed & operand_b[W-1];
  assign w_a_mag  = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag  = w_b_neg ? -operand_b : operand_b;

  // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right
  assign w_add = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opnd} : '0);

  // Restoring divide step; remainder stays below the divisor, so the difference fits W bits
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_ge    = w_shift >= {1'b0, r_opnd};
  assign w_diff  = w_shift[W-1:0] - r_opnd;

  assign w_prod     = {r_rem, r_quo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

  assign busy       = (r_state != S_IDLE);
  assign stall      = (w_muldiv | w_mt | w_mfhi | w_mflo) & busy;
  assign done       = r_done;
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign mdu_sel    = w_mfhi | w_mflo;
  assign mdu_result = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);

  always_comb begin
    operation = 4'b0000;
    case (ula_operation)
      3'b000: operation = 4'b0010;
      3'b001: operation = 4'b0110;
      3'b010: begin
        case (func)
          6'b000100: operation = 4'b1110;
          6'b000110: operation = 4'b1111;
          6'b000111: operation = 4'b1111;
          6'b100000: operation = 4'b0010;
          6'b100010: operation = 4'b0110;
          6'b100100: operation = 4'b0000;
          6'b100101: operation = 4'b0001;
          6'b100110: operation = 4'b1101;
          6'b100111: operation = 4'b1100;
          6'b101010: operation = 4'b0111;
          6'b101011: operation = 4'b0111;
          default:   operation = 4'b0000;
        endcase
      end
      3'b011: operation = 4'b0111;
      3'b100: operation = 4'b0000;
      3'b101: operation = 4'b0001;
      3'b110: operation = 4'b1101;
      3'b111: operation = 4'b1011;
      default: operation = 4'b0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_muldiv) begin
            r_is_div <= func[1];
            r_cnt    <= CNT_WIDTH'(W);
            r_rem    <= '0;
            if (!func[1]) begin
              r_quo   <= w_b_mag;
              r_opnd  <= w_a_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= 1'b0;
              r_state <= S_MUL;
            end else if (operand_b == '0) begin
              // Divide by zero: preload the FIX result directly (hi=dividend, lo=all ones)
              r_rem   <= operand_a;
              r_quo   <= '1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else begin
              r_quo   <= w_a_mag;
              r_opnd  <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_state <= S_DIV;
            end
          end else if (w_mt) begin
            if (func[1]) r_lo <= operand_a;
            else         r_hi <= operand_a;
          end
        end
        S_MUL: begin
          r_rem <= w_add[W:1];
          r_quo <= {w_add[0], r_quo[W-1:1]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_WIDTH'(1)) r_state <= S_FIX;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_shift[W-1:0];
          r_quo <= {r_quo[W-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_WIDTH'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*W-1:W];
            r_lo <= w_prod_fix[W-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_mdu_control.sv
// tb/tb_ula_mdu_control.sv - randomized self-checking bench for ula_mdu_control against a behavioural model
module tb_ula_mdu_control;
  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [2:0]   ula_operation;
  logic [5:0]   func;
  logic         start;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [3:0]   operation;
  logic         mdu_sel;
  logic [W-1:0] mdu_result;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  ula_mdu_control #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clock(clock), .reset_n(reset_n), .ula_operation(ula_operation), .func(func),
    .start(start), .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
    .mdu_sel(mdu_sel), .mdu_result(mdu_result), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] ref_alu_op(input logic [2:0] u, input logic [5:0] f);
    case (u)
      3'd0: return 4'b0010;
      3'd1: return 4'b0110;
      3'd3: return 4'b0111;
      3'd4: return 4'b0000;
      3'd5: return 4'b0001;
      3'd6: return 4'b1101;
      3'd7: return 4'b1011;
      default: begin
        case (f)
          6'b000100: return 4'b1110;
          6'b000110, 6'b000111: return 4'b1111;
          6'b100000: return 4'b0010;
          6'b100010: return 4'b0110;
          6'b100101: return 4'b0001;
          6'b100110: return 4'b1101;
          6'b100111: return 4'b1100;
          6'b101010, 6'b101011: return 4'b0111;
          default: return 4'b0000;
        endcase
      end
    endcase
  endfunction

  // Plain-arithmetic reference: 64-bit products, truncating division with remainder sign of dividend
  task automatic ref_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p = '0;
    h = '0;
    l = '0;
    if (f == F_MULT || f == F_MULTU) begin
      if (f == F_MULT) p = sa * sb;
      else             p = ua * ub;
      h = p[63:32];
      l = p[31:0];
    end else if (b == '0) begin
      h = a;
      l = '1;
    end else begin
      if (f == F_DIV) begin q = sa / sb; r = sa % sb; end
      else            begin q = ua / ub; r = ua % ub; end
      h = r[31:0];
      l = q[31:0];
    end
  endtask

  task automatic drive_idle();
    start = 1'b0; ula_operation = 3'b000; func = 6'b000000;
    operand_a = $urandom; operand_b = $urandom;
  endtask

  // Latency is counted in clock edges after the accepting edge until done is seen high:
  // DATA_WIDTH iterations + FIX, or FIX alone for divide-by-zero (done in the second cycle
  // counting the accepting cycle as the first).
  task automatic run_muldiv(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int lat, exp_lat;
    ref_mdu(f, a, b, eh, el);
    exp_lat = (f[1] && b == '0) ? 1 : W + 1;
    @(negedge clock);
    ula_operation = 3'b010; func = f; start = 1'b1; operand_a = a; operand_b = b;
    #1 check_eq("stall_when_idle", stall, 0);
    @(posedge clock); #1 drive_idle();
    check_eq("busy_after_accept", busy, 1);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (done) begin lat = k; break; end
    end
    check_eq("done_latency", lat, exp_lat);
    check_eq("hi_result", hi, eh);
    check_eq("lo_result", lo, el);
    check_eq("busy_after_done", busy, 0);
    exp_hi = eh; exp_lo = el;
    @(posedge clock); #1 check_eq("done_one_pulse", done, 0);
  endtask

  task automatic run_mt(input logic [5:0] f, input logic [W-1:0] a);
    @(negedge clock);
    ula_operation = 3'b010; func = f; start = 1'b1; operand_a = a; operand_b = $urandom;
    #1 check_eq("mt_stall", stall, 0);
    @(posedge clock); #1 drive_idle();
    if (f == F_MTHI) exp_hi = a; else exp_lo = a;
    check_eq("mt_hi", hi, exp_hi);
    check_eq("mt_lo", lo, exp_lo);
    check_eq("mt_busy", busy, 0);
  endtask

  task automatic run_mf(input logic [5:0] f);
    @(negedge clock);
    ula_operation = 3'b010; func = f; start = 1'b1;
    #1;
    check_eq("mf_sel", mdu_sel, 1);
    check_eq("mf_result", mdu_result, (f == F_MFHI) ? exp_hi : exp_lo);
    check_eq("mf_stall", stall, 0);
    drive_idle();
    #1 check_eq("mf_sel_idle", mdu_sel, 0);
  endtask

  logic [5:0] flist [20] = '{6'b000100, 6'b000110, 6'b000111, 6'b100000, 6'b100010,
                             6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010,
                             6'b101011, 6'b111111, 6'b010000, 6'b010001, 6'b010010,
                             6'b010011, 6'b011000, 6'b011001, 6'b011010, 6'b011011};

  initial begin
    logic [W-1:0] a, b, eh, el;
    logic [5:0] f;
    int kind;

    reset_n = 1'b0;
    drive_idle();
    exp_hi = '0; exp_lo = '0;
    #1;
    check_eq("reset_hi", hi, 0);
    check_eq("reset_lo", lo, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_stall", stall, 0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    // Decode sweep; MDU functs with start=1 under R-type are exercised by the MDU tests
    for (int u = 0; u < 8; u++) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < 20; i++) begin
          if (!(u == 2 && s == 1 && i >= 12)) begin
            ula_operation = 3'(u); start = 1'(s); func = flist[i];
            #1;
            check_eq("decode_op", operation, ref_alu_op(3'(u), flist[i]));
            check_eq("decode_stall", stall, 0);
          end
        end
      end
    end
    drive_idle();
    #1 check_eq("sweep_no_action_busy", busy, 0);
    check_eq("sweep_no_action_hi", hi, 0);

    // Directed cases
    run_muldiv(F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    run_muldiv(F_MULT,  32'hFFFF_FFFD, 32'h0000_0007);
    run_muldiv(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_muldiv(F_DIVU,  32'd100,       32'd7);
    run_muldiv(F_DIV,   32'd5,         32'd0);
    run_muldiv(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

    // Randomized mix of MDU operations
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 5);
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : $urandom);
      case (kind)
        0: run_muldiv(F_MULT, a, b);
        1: run_muldiv(F_MULTU, a, b);
        2: run_muldiv(F_DIV, a, b);
        3: run_muldiv(F_DIVU, a, b);
        4: run_mt(($urandom_range(0, 1) == 0) ? F_MTHI : F_MTLO, a);
        default: run_mf(($urandom_range(0, 1) == 0) ? F_MFHI : F_MFLO);
      endcase
    end

    // MFLO presented 3 cycles after MULT: stalled through FIX, then reads the new LO
    a = $urandom; b = $urandom;
    ref_mdu(F_MULT, a, b, eh, el);
    @(negedge clock);
    ula_operation = 3'b010; func = F_MULT; start = 1'b1; operand_a = a; operand_b = b;
    @(posedge clock); #1 drive_idle();
    @(posedge clock); #1;
    @(posedge clock); #1;
    ula_operation = 3'b010; func = F_MFLO; start = 1'b1;
    for (int e = 2; e <= W + 1; e++) begin
      #1 check_eq("mflo_stall", stall, (e <= W) ? 1 : 0);
      if (e == 10) begin
        func = 6'b100000;
        #1;
        check_eq("add_during_busy_stall", stall, 0);
        check_eq("add_during_busy_op", operation, 4'b0010);
        func = F_MFLO;
      end
      if (e <= W) begin @(posedge clock); #1; end
    end
    check_eq("mflo_done", done, 1);
    check_eq("mflo_sel", mdu_sel, 1);
    check_eq("mflo_result", mdu_result, el);
    drive_idle();
    exp_hi = eh; exp_lo = el;
    @(posedge clock); #1 check_eq("mflo_hi_kept", hi, exp_hi);

    // Reset mid-DIV aborts the operation
    @(negedge clock);
    ula_operation = 3'b010; func = F_DIV; start = 1'b1; operand_a = $urandom; operand_b = $urandom_range(1, 1000);
    @(posedge clock); #1 drive_idle();
    repeat (9) @(posedge clock);
    #1 check_eq("busy_mid_div", busy, 1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clock); reset_n = 1'b1;
    run_mt(F_MTHI, 32'h0000_1234);
    run_mf(F_MFHI);
    run_mf(F_MFLO);
    repeat (W + 3) begin
      @(posedge clock); #1 check_eq("no_done_after_abort", done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
